instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl_pkg.sv | 32 +++
 rtl/instr_fetch_ctrl_watchdog.sv | 49 ++++
 rtl/instr_fetch_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
// Holds the controller state encoding, the opcode constants that the
// decoder cares about, and the fault code values reported on faultCode.
package instr_fetch_ctrl_pkg;

  // Controller states (legacy-compatible plain constants)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  // Opcodes held in IR[15:12]
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUBI = 4'h2;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Values reported on faultCode
  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ILLEGAL = 2'b01,
    FC_TIMEOUT = 2'b10
  } fault_code_e;

  // An opcode is accepted when its bit is set in the one-hot legal mask.
  function automatic logic op_is_legal(input logic [15:0] mask, input logic [3:0] op);
    return mask[op];
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_watchdog.sv
// exec_watchdog: counts EXEC cycles and flags when an instruction has
// used its full budget of TIMEOUT cycles without completing.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : zero the counter (issued as an instruction enters EXEC)
//   enable     : count this cycle (high while in EXEC)
//   expired    : high during the TIMEOUT-th enabled cycle since clear
module exec_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Enough bits to hold TIMEOUT-1, the count seen during the last allowed cycle
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The counter holds k-1 during the k-th EXEC cycle, so expiry lands on cycle TIMEOUT
  assign expired = enable && (cnt_q == LIMIT);

  // Next-count logic: clear wins, then count until the limit is reached
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch/decode/dispatch controller for a small CPU.
// Fetches a word at PC, decodes the opcode in IR[15:12], handles NOP and
// HALT itself and hands other legal instructions to the execution FSMs
// through the instruction output until they signal done.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   run                : level, allows leaving IDLE
//   memReq/memAddr     : read request and address (address is PC)
//   memAck/memData     : read completion and returned word
//   instruction        : IR while in EXEC, zero otherwise
//   pcInc/done         : PC increment and completion from execution FSMs
//   busy/halted/fault  : status flags
//   faultCode          : 00 none, 01 illegal opcode, 10 exec timeout
//   retired            : count of completed instructions (wraps)
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter logic [15:0] LEGAL_OPS = 16'h8007,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        memReq,
  output logic [15:0] memAddr,
  input  logic        memAck,
  input  logic [15:0] memData,
  output logic [15:0] instruction,
  input  logic        pcInc,
  input  logic        done,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  faultCode,
  output logic [15:0] retired
);

  logic [2:0]  state_q,   state_d;
  logic [15:0] pc_q,      pc_d;
  logic [15:0] ir_q,      ir_d;
  logic [15:0] retired_q, retired_d;
  fault_code_e fcode_q,   fcode_d;

  // Output flops are loaded from next-state values so that they line up
  // with the state register and clear asynchronously with it.
  logic        memreq_q,  memreq_d;
  logic [15:0] instr_q,   instr_d;
  logic        busy_q,    busy_d;
  logic        halted_q,  halted_d;
  logic        fault_q,   fault_d;

  logic [3:0]  op_s;
  logic        wd_clear_s;
  logic        wd_en_s;
  logic        wd_expired_s;

  assign op_s = ir_q[15:12];

  exec_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (wd_clear_s),
    .enable  (wd_en_s),
    .expired (wd_expired_s)
  );

  // Next-state, PC, IR, retired and fault-code logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    retired_d  = retired_q;
    fcode_d    = fcode_q;
    wd_clear_s = 1'b0;
    wd_en_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (memAck) begin
          ir_d    = memData;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        // Legality is checked first so a mask without NOP/HALT still faults them
        if (!op_is_legal(LEGAL_OPS, op_s)) begin
          fcode_d = FC_ILLEGAL;
          state_d = ST_FAULT;
        end else if (op_s == OP_NOP) begin
          pc_d      = pc_q + 16'd1;
          retired_d = retired_q + 16'd1;
          state_d   = ST_FETCH;
        end else if (op_s == OP_HALT) begin
          retired_d = retired_q + 16'd1;
          state_d   = ST_HALT;
        end else begin
          wd_clear_s = 1'b1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        wd_en_s = 1'b1;
        if (pcInc) begin
          pc_d = pc_q + 16'd1;
        end else begin
          pc_d = pc_q;
        end
        // done beats the watchdog when both land on the same cycle
        if (done) begin
          retired_d = retired_q + 16'd1;
          state_d   = ST_FETCH;
        end else if (wd_expired_s) begin
          fcode_d = FC_TIMEOUT;
          state_d = ST_FAULT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        // Unreachable encodings recover to a safe idle
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the cycle following the coming edge
  always_comb begin
    memreq_d = (state_d == ST_FETCH);
    busy_d   = (state_d == ST_FETCH) || (state_d == ST_DECODE) || (state_d == ST_EXEC);
    halted_d = (state_d == ST_HALT);
    fault_d  = (state_d == ST_FAULT);
    if (state_d == ST_EXEC) begin
      instr_d = ir_d;
    end else begin
      instr_d = 16'h0000;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= 16'h0000;
      ir_q      <= 16'h0000;
      retired_q <= 16'h0000;
      fcode_q   <= FC_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      fcode_q   <= fcode_d;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memreq_q <= 1'b0;
      instr_q  <= 16'h0000;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      memreq_q <= memreq_d;
      instr_q  <= instr_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign memReq      = memreq_q;
  assign memAddr     = pc_q;
  assign instruction = instr_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign faultCode   = fcode_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: stimulus pushes expected fetch
// addresses and dispatched instruction words; a monitor pops and compares
// them whenever a new memory request or a new EXEC instruction appears.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        memReq;
  logic [15:0] memAddr;
  logic        memAck = 1'b0;
  logic [15:0] memData = 16'h0000;
  logic [15:0] instruction;
  logic        pcInc = 1'b0;
  logic        done = 1'b0;
  logic        busy, halted, fault;
  logic [1:0]  faultCode;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_instr_q[$];

  instr_fetch_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .memReq(memReq), .memAddr(memAddr),
    .memAck(memAck), .memData(memData), .instruction(instruction),
    .pcInc(pcInc), .done(done), .busy(busy), .halted(halted), .fault(fault),
    .faultCode(faultCode), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every new fetch request and every newly dispatched instruction
  logic prev_req = 1'b0;
  logic [15:0] prev_instr = 16'h0000;
  always @(negedge clk) begin
    if (memReq && !prev_req) begin
      if (exp_addr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected_fetch actual=%0h required=none", memAddr);
      end else begin
        chk("sb_fetch_addr", {16'h0, memAddr}, {16'h0, exp_addr_q.pop_front()});
      end
    end
    if (instruction != 16'h0000 && prev_instr == 16'h0000) begin
      if (exp_instr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected_instr actual=%0h required=none", instruction);
      end else begin
        chk("sb_instr", {16'h0, instruction}, {16'h0, exp_instr_q.pop_front()});
      end
    end
    prev_req   = memReq;
    prev_instr = instruction;
  end

  // Assert reset at a falling edge, check outputs drop at once and stay cleared
  task automatic do_reset();
    @(negedge clk);
    run = 1'b0; memAck = 1'b0; pcInc = 1'b0; done = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_async_fault",  {31'h0, fault},  32'h0);
    chk("rst_async_halted", {31'h0, halted}, 32'h0);
    chk("rst_async_memreq", {31'h0, memReq}, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_busy",    {31'h0, busy},        32'h0);
    chk("rst_fcode",   {30'h0, faultCode},   32'h0);
    chk("rst_retired", {16'h0, retired},     32'h0);
    chk("rst_addr",    {16'h0, memAddr},     32'h0);
    chk("rst_instr",   {16'h0, instruction}, 32'h0);
    rst = 1'b1;
  endtask

  // Wait (bounded) for a request, hold off 'delay' cycles, then return 'data'.
  // Returns at the falling edge of the DECODE cycle.
  task automatic fetch_word(input logic [15:0] data, input int delay);
    for (int i = 0; i < 50 && !memReq; i++) @(negedge clk);
    chk("fetch_req_seen", {31'h0, memReq}, 32'h1);
    for (int i = 0; i < delay; i++) @(negedge clk);
    memAck = 1'b1; memData = data;
    @(negedge clk);
    memAck = 1'b0; memData = 16'h0000;
  endtask

  // Drive n EXEC cycles: pcInc in the first 'inc' cycles, done in the last if requested
  task automatic run_exec(input int n, input int inc, input bit with_done);
    for (int k = 1; k <= n; k++) begin
      pcInc = (k <= inc);
      done  = with_done && (k == n);
      @(negedge clk);
    end
    pcInc = 1'b0; done = 1'b0;
  endtask

  // Pulse memAck outside FETCH and confirm nothing is requested
  task automatic stray_acks(input logic [15:0] data);
    for (int i = 0; i < 3; i++) begin
      memAck = 1'b1; memData = data;
      @(negedge clk);
      chk("absorb_memreq", {31'h0, memReq}, 32'h0);
    end
    memAck = 1'b0; memData = 16'h0000;
  endtask

  int exec_cnt;

  initial begin
    do_reset();
    @(negedge clk);
    chk("idle_no_run", {31'h0, busy}, 32'h0);

    // Basic fetch with 3-cycle memory delay, one pcInc then done
    exp_addr_q.push_back(16'h0000);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;                                  // no effect once FETCH is entered
    exp_instr_q.push_back(16'h1045);
    exp_addr_q.push_back(16'h0001);
    fetch_word(16'h1045, 3);
    chk("decode_instr_zero", {16'h0, instruction}, 32'h0);
    chk("decode_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("exec_latency_instr", {16'h0, instruction}, 32'h1045);
    run_exec(2, 1, 1'b1);
    chk("a_pc", {16'h0, memAddr}, 32'h1);
    chk("a_retired", {16'h0, retired}, 32'h1);

    // pcInc together with done
    exp_instr_q.push_back(16'h1234);
    exp_addr_q.push_back(16'h0002);
    fetch_word(16'h1234, 0);
    @(negedge clk);
    run_exec(1, 1, 1'b1);
    chk("b_pc", {16'h0, memAddr}, 32'h2);
    chk("b_retired", {16'h0, retired}, 32'h2);

    // 258 instructions, each done on EXEC cycle 254 with pcInc every cycle
    for (int i = 0; i < 258; i++) begin
      exp_instr_q.push_back(16'h2ABC);
      exp_addr_q.push_back(16'h0002 + 16'(254 * (i + 1)));
      fetch_word(16'h2ABC, 0);
      @(negedge clk);
      run_exec(254, 254, 1'b1);
      if (i == 0) begin
        chk("done_254_no_fault", {31'h0, fault}, 32'h0);
        chk("done_254_fetch", {31'h0, memReq}, 32'h1);
      end
    end
    exp_instr_q.push_back(16'h1001);
    exp_addr_q.push_back(16'hFFFF);
    fetch_word(16'h1001, 0);
    @(negedge clk);
    run_exec(1, 1, 1'b1);
    chk("pc_at_ffff", {16'h0, memAddr}, 32'hFFFF);

    // NOP at FFFF wraps PC and never reaches EXEC
    exp_addr_q.push_back(16'h0000);
    fetch_word(16'h0000, 0);
    chk("nop_instr_decode", {16'h0, instruction}, 32'h0);
    @(negedge clk);
    chk("nop_wrap_pc", {16'h0, memAddr}, 32'h0);
    chk("nop_retired", {16'h0, retired}, 32'h106);
    chk("nop_instr_fetch", {16'h0, instruction}, 32'h0);

    // Exec timeout with done withheld
    exp_instr_q.push_back(16'h1001);
    fetch_word(16'h1001, 0);
    exec_cnt = 0;
    for (int i = 0; i < 400 && !fault; i++) begin
      @(negedge clk);
      if (instruction != 16'h0000) exec_cnt++;
    end
    chk("timeout_fault", {31'h0, fault}, 32'h1);
    chk("timeout_cycles", exec_cnt, 32'd255);
    chk("timeout_fcode", {30'h0, faultCode}, 32'h2);
    chk("timeout_busy", {31'h0, busy}, 32'h0);
    stray_acks(16'h1111);
    chk("timeout_retired_hold", {16'h0, retired}, 32'h106);
    chk("timeout_fault_hold", {31'h0, fault}, 32'h1);
    do_reset();

    // Illegal opcode 5
    exp_addr_q.push_back(16'h0000);
    run = 1'b1;
    fetch_word(16'h5000, 0);
    run = 1'b0;
    @(negedge clk);
    chk("illegal_fault", {31'h0, fault}, 32'h1);
    chk("illegal_fcode", {30'h0, faultCode}, 32'h1);
    chk("illegal_memreq", {31'h0, memReq}, 32'h0);
    stray_acks(16'h0000);
    chk("illegal_fault_hold", {31'h0, fault}, 32'h1);
    do_reset();

    // NOP then HALT: PC stays at 1, retired counts both
    exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0001);
    run = 1'b1;
    fetch_word(16'h0000, 1);
    run = 1'b0;
    fetch_word(16'hF000, 0);
    @(negedge clk);
    chk("halt_halted", {31'h0, halted}, 32'h1);
    chk("halt_retired", {16'h0, retired}, 32'h2);
    chk("halt_pc", {16'h0, memAddr}, 32'h1);
    chk("halt_busy", {31'h0, busy}, 32'h0);
    stray_acks(16'h0000);
    chk("halt_retired_hold", {16'h0, retired}, 32'h2);
    chk("halt_pc_hold", {16'h0, memAddr}, 32'h1);
    chk("halt_hold", {31'h0, halted}, 32'h1);
    do_reset();

    // Reset in the middle of a FETCH cycle
    exp_addr_q.push_back(16'h0000);
    run = 1'b1;
    for (int i = 0; i < 10 && !memReq; i++) @(negedge clk);
    run = 1'b0;
    #2 rst = 1'b0;
    #1 chk("rst_mid_fetch_memreq", {31'h0, memReq}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of EXEC with pcInc held high
    exp_addr_q.push_back(16'h0000);
    exp_instr_q.push_back(16'h1002);
    run = 1'b1;
    fetch_word(16'h1002, 0);
    run = 1'b0;
    @(negedge clk);
    pcInc = 1'b1;
    repeat (2) @(negedge clk);
    chk("exec_pc_before_rst", {16'h0, memAddr}, 32'h2);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_exec_instr", {16'h0, instruction}, 32'h0);
    chk("rst_mid_exec_memreq", {31'h0, memReq}, 32'h0);
    chk("rst_mid_exec_pc", {16'h0, memAddr}, 32'h0);
    chk("rst_mid_exec_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("rst_hold_pc_no_inc", {16'h0, memAddr}, 32'h0);
    pcInc = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    chk("sb_addr_drained", exp_addr_q.size(), 32'd0);
    chk("sb_instr_drained", exp_instr_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
